pe27_patch_loader: RTL and testbench

- Upstream feeder for `pe27_mac`.
- Takes a valid/ready byte stream of (weight, activation) pairs and packs 27 pairs into the flat 216-bit weight and input buses.
- Issues a one-cycle start pulse to the MAC, waits for its done pulse, and returns the 24-bit result on a valid/ready output port.
- Sits between the conv window/weight fetch logic and the 27-term MAC of each PE.

---
 rtl/pe27_pkg.sv | 20 ++
 rtl/pe27_patch_loader.sv | 150 +++++++++++++++
 tb/tb_pe27_patch_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe27_pkg.sv
// Shared constants and FSM encoding for the pe27 MAC and its patch loader.
package pe27_pkg;

    localparam int unsigned N_TERMS = 27;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned FLAT_W  = N_TERMS * DATA_W;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WDOG_W  = 15;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/pe27_patch_loader.sv
// Packs 27 (weight, activation) pairs for pe27_mac, fires it and returns the result.
// Optional MAC watchdog enabled by defining PE27_LOADER_TIMEOUT_EN.
module pe27_patch_loader
    import pe27_pkg::*;
`ifdef PE27_LOADER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 20000
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_weight,
    input  logic [DATA_W-1:0] s_act,
    input  logic              s_last,
    output logic              mac_start,
    output logic [FLAT_W-1:0] mac_weights_flat,
    output logic [FLAT_W-1:0] mac_inputs_flat,
    input  logic              mac_busy,
    input  logic              mac_done,
    input  logic [ACC_W-1:0]  mac_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic              frame_err,
    output logic              timeout_err
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             s_hs;
    logic             m_hs;
    logic             at_last;
    logic             wdog_expire;

    // Busy is informational only; control relies solely on the done pulse.
    logic unused_busy;
    assign unused_busy = mac_busy;

    assign s_hs    = s_valid && s_ready;
    assign m_hs    = m_valid && m_ready;
    assign at_last = (cnt == LAST_SLOT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; mac_done takes priority over watchdog expiry
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (s_hs && at_last) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    state_nxt = S_OUT;
                end else if (wdog_expire) begin
                    state_nxt = S_LOAD;
                end
            end
            S_OUT: begin
                if (m_hs) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // Handshake/strobe outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready   <= 1'b0;
            mac_start <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
        end else begin
            s_ready   <= (state_nxt == S_LOAD);
            mac_start <= (state_nxt == S_START);
            m_valid   <= (state_nxt == S_OUT);
            if ((state == S_WAIT) && mac_done) begin
                m_data <= mac_out;
            end
        end
    end

    // Slot counter, slot write decode and framing check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            mac_weights_flat <= '0;
            mac_inputs_flat  <= '0;
            frame_err        <= 1'b0;
        end else if (s_hs) begin
            cnt <= at_last ? '0 : cnt + CNT_W'(1);
            for (int k = 0; k < int'(N_TERMS); k++) begin
                if (cnt == CNT_W'(k)) begin
                    mac_weights_flat[k*DATA_W +: DATA_W] <= s_weight;
                    mac_inputs_flat[k*DATA_W +: DATA_W]  <= s_act;
                end
            end
            if (s_last != at_last) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef PE27_LOADER_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_expire = (wdog_cnt == WDOG_W'(TIMEOUT_CYC - 1));

    // Watchdog counts S_WAIT cycles; expiry drops the patch and flags it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_START) begin
                wdog_cnt <= '0;
            end else if (state == S_WAIT) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if ((state == S_WAIT) && !mac_done && wdog_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe27_patch_loader.sv
// Directed bench for pe27_patch_loader with a behavioural pe27_mac stand-in.
module tb_pe27_patch_loader;
    import pe27_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_weight;
    logic [DATA_W-1:0] s_act;
    logic              s_last;
    logic              mac_start;
    logic [FLAT_W-1:0] mac_weights_flat;
    logic [FLAT_W-1:0] mac_inputs_flat;
    logic              mac_busy;
    logic              mac_done;
    logic [ACC_W-1:0]  mac_out;
    logic              m_valid;
    logic              m_ready;
    logic [ACC_W-1:0]  m_data;
    logic              frame_err;
    logic              timeout_err;

    int n_checks;
    int n_errors;
    int hs_cnt;
    int start_cnt;
    int mac_lat;
    bit mac_en;

    logic [DATA_W-1:0] w_arr [N_TERMS];
    logic [DATA_W-1:0] a_arr [N_TERMS];

`ifdef PE27_LOADER_TIMEOUT_EN
    pe27_patch_loader #(.TIMEOUT_CYC(16)) dut (
`else
    pe27_patch_loader dut (
`endif
        .clk              (clk),
        .rst_n            (rst_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_weight         (s_weight),
        .s_act            (s_act),
        .s_last           (s_last),
        .mac_start        (mac_start),
        .mac_weights_flat (mac_weights_flat),
        .mac_inputs_flat  (mac_inputs_flat),
        .mac_busy         (mac_busy),
        .mac_done         (mac_done),
        .mac_out          (mac_out),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .frame_err        (frame_err),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: sums the products seen on the buses, answers after mac_lat cycles
    initial begin
        logic [ACC_W-1:0] sum;
        mac_done = 1'b0;
        mac_out  = '0;
        mac_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mac_start && mac_en) begin
                sum = '0;
                for (int k = 0; k < int'(N_TERMS); k++) begin
                    sum = sum + ACC_W'(mac_weights_flat[k*8 +: 8]) * ACC_W'(mac_inputs_flat[k*8 +: 8]);
                end
                mac_busy = 1'b1;
                repeat (mac_lat - 1) @(negedge clk);
                mac_out  = sum;
                mac_done = 1'b1;
                @(negedge clk);
                mac_done = 1'b0;
                mac_busy = 1'b0;
            end
        end
    end

    always @(posedge clk) if (rst_n && s_valid && s_ready) hs_cnt++;
    always @(negedge clk) if (mac_start) start_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] w, input logic [7:0] a, input int n);
        for (int i = 0; i < int'(N_TERMS); i++) begin
            w_arr[i] = (i < n) ? w : 8'd0;
            a_arr[i] = (i < n) ? a : 8'd0;
        end
    endtask

    // Returns at the negedge just after the final handshake (the mac_start cycle)
    task automatic run_patch(input int last_idx, input int gap_max);
        hs_cnt    = 0;
        start_cnt = 0;
        for (int i = 0; i < int'(N_TERMS); i++) begin
            int b;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            s_valid  = 1'b1;
            s_weight = w_arr[i];
            s_act    = a_arr[i];
            s_last   = (i == last_idx);
            b = 0;
            while (!s_ready && b < 200) begin
                @(negedge clk);
                b++;
            end
            if (b >= 200) check("s_ready_wait", 32'(s_ready), 32'd1);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic get_result(input string tag, input logic [ACC_W-1:0] exp);
        int b;
        b = 0;
        while (!m_valid && b < 100) begin
            @(negedge clk);
            b++;
        end
        check({tag, "_m_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_m_data"}, 32'(m_data), 32'(exp));
    endtask

    task automatic release_result(input string tag);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_s_ready_after"}, 32'(s_ready), 32'd1);
        check({tag, "_m_valid_after"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mac_lat  = 3;
        mac_en   = 1'b1;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_weight = '0;
        s_act    = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_mac_start", 32'(mac_start), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_wflat", 32'(|mac_weights_flat), 32'd0);
        check("rst_iflat", 32'(|mac_inputs_flat), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_s_ready", 32'(s_ready), 32'd1);

        // All ones
        fill(8'd1, 8'd1, 27);
        run_patch(26, 0);
        check("ones_start_now", 32'(mac_start), 32'd1);
        get_result("ones", 24'd27);
        check("ones_start_width", 32'(start_cnt), 32'd1);
        check("ones_frame_err", 32'(frame_err), 32'd0);
        release_result("ones");

        // Partial patch: slots 0..8 = (2,3)
        fill(8'd2, 8'd3, 9);
        run_patch(26, 0);
        get_result("part", 24'd54);
        check("part_w0", 32'(mac_weights_flat[7:0]), 32'd2);
        check("part_w9", 32'(mac_weights_flat[79:72]), 32'd0);
        check("part_i8", 32'(mac_inputs_flat[71:64]), 32'd3);
        release_result("part");

        // Input bubbles and output stall
        fill(8'd1, 8'd1, 27);
        mac_lat = 5;
        run_patch(26, 2);
        get_result("stall", 24'd27);
        check("stall_hs_cnt", 32'(hs_cnt), 32'd27);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_m_valid", 32'(m_valid), 32'd1);
            check("stall_m_data", 32'(m_data), 32'd27);
            check("stall_s_ready", 32'(s_ready), 32'd0);
        end
        release_result("stall");
        mac_lat = 3;

        // Early s_last on pair 10 (and missing on pair 27)
        fill(8'd1, 8'd1, 27);
        run_patch(9, 0);
        check("early_frame_err", 32'(frame_err), 32'd1);
        get_result("early", 24'd27);
        release_result("early");
        check("early_frame_sticky", 32'(frame_err), 32'd1);

        // MAC never answers
        mac_en = 1'b0;
        fill(8'd1, 8'd1, 27);
        run_patch(26, 0);
`ifdef PE27_LOADER_TIMEOUT_EN
        repeat (16) @(negedge clk);
        check("wd_pre_s_ready", 32'(s_ready), 32'd0);
        check("wd_pre_timeout", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("wd_timeout_err", 32'(timeout_err), 32'd1);
        check("wd_s_ready", 32'(s_ready), 32'd1);
        check("wd_m_valid", 32'(m_valid), 32'd0);
        repeat (5) @(negedge clk);
        check("wd_m_valid_later", 32'(m_valid), 32'd0);
        check("wd_sticky", 32'(timeout_err), 32'd1);
`else
        repeat (40) @(negedge clk);
        check("nowd_s_ready", 32'(s_ready), 32'd0);
        check("nowd_timeout_err", 32'(timeout_err), 32'd0);
        check("nowd_m_valid", 32'(m_valid), 32'd0);
`endif

        // Reset asserted mid-wait
        if (s_ready) run_patch(26, 0);
        repeat (3) @(negedge clk);
        check("mid_in_wait", 32'(s_ready), 32'd0);
        start_cnt = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        check("mid_rst_wflat", 32'(|mac_weights_flat), 32'd0);
        check("mid_rst_iflat", 32'(|mac_inputs_flat), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_no_start", 32'(start_cnt), 32'd0);
        @(negedge clk);
        check("mid_rel_s_ready", 32'(s_ready), 32'd1);
        mac_en = 1'b1;
        fill(8'd1, 8'd1, 27);
        run_patch(26, 0);
        get_result("post_rst", 24'd27);
        check("post_rst_frame_err", 32'(frame_err), 32'd0);
        release_result("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
